rd53_prog_delay_line: RTL
=========================

// Module: rd53_prog_delay_line
// PURPOSE
//  Multi-channel, clock-cycle-programmable delay line. Successor to the fixed DELx delay cells and CKMUX2 select cells.
//  Each of NCH 1-bit channels passes through its own shift register. A per-channel tap mux selects the delay.
//  Delay and source are reconfigured at run time through a valid/ready config port.
//  Sits between the command/trigger decode and the readout/test-pulse logic to align per-channel timing.
// PARAMETERS
//  NCH          4   number of independent channels (1..32)
//  MAX_DLY      15  largest programmable delay, in CLK cycles (1..255)
//  DEFAULT_DLY  0   per-channel delay loaded at reset (0..MAX_DLY)
//  FREEZE_CYC   2   cycles a channel output is held after a delay change (1..15)
// PORTS
//  CLK        in   1                 single clock, all logic rising-edge
//  RST        in   1                 asynchronous, active-high reset
//  din        in   NCH               channel data inputs
//  dout       out  NCH               delayed channel outputs
//  cfg_valid  in   1                 config request
//  cfg_ready  out  1                 block can accept config
//  cfg_ch     in   clog2(NCH)        target channel (minimum width 1)
//  cfg_dly    in   clog2(MAX_DLY+1)  requested delay
//  cfg_src    in   1                 0 = din[ch], 1 = internal toggle pattern
//  cfg_err    out  1                 1-cycle pulse: bad channel or clamped delay
//  busy       out  NCH               channel output currently frozen
// BEHAVIOUR
//  Reset (async assert, sync-safe release):
//   - shift regs 0, dout 0, dly[*] = DEFAULT_DLY, src[*] = 0.
//   - busy 0, cfg_ready 1, cfg_err 0, toggle generator 0.
//  Datapath:
//   - sr[ch] shifts in the selected source every cycle; sr[ch][0] is the newest sample.
//   - dout[ch] is registered from sr[ch][dly[ch]].
//   - Total latency din -> dout = dly + 2 cycles. dly = 0 gives 2 cycles.
//   - Toggle generator: 1 flop, inverts every cycle, shared by all channels.
//  Config handshake:
//   - A transfer happens on a cycle with cfg_valid & cfg_ready.
//   - cfg_ready = ~|busy; at most one channel reconfigures at a time.
//   - Inputs must be held stable while cfg_valid=1 and cfg_ready=0.
//   - cfg_ch >= NCH: transfer accepted, nothing changes, cfg_err pulses the next cycle.
//   - cfg_dly > MAX_DLY: clamped to MAX_DLY, applied, cfg_err pulses the next cycle.
//   - dly/src update on the accepting edge; busy[ch] is set on the same edge.
//  Freeze (glitch suppression, replaces the async CKMUX behaviour):
//   - Per-channel FSM IDLE -> FREEZE -> IDLE.
//   - IDLE: dout follows the tap. On an accepted transfer to this channel: go to FREEZE, load cnt = FREEZE_CYC-1.
//   - FREEZE: dout holds its last value and busy=1. Decrement cnt; at 0 return to IDLE.
//   - dout resumes from the new tap on the following cycle.
//   - The shift register keeps running during FREEZE, so no samples are lost.
//   - Transfer with an unchanged dly/src still enters FREEZE; the behaviour is uniform.
//  Boundaries:
//   - Delay change upward repeats samples; downward skips samples. Both are hidden by the freeze, not corrected.
//   - RST during FREEZE: the FSM aborts to IDLE and all state returns to reset values.
//   - cfg_valid asserted in the same cycle RST deasserts: accepted, because cfg_ready=1.
//   - Unused high bits of cfg_ch/cfg_dly are not ignored: range checks use the full value.
// STRUCTURE
//  Package rd53_delay_pkg:
//   - clog2 function, localparam widths CH_W / DLY_W.
//   - enum type freeze_state_t {IDLE, FREEZE}.
//  Sub-module rd53_delay_chan, one per channel via generate:
//   - shift register, tap mux, source mux, freeze FSM/counter, output register.
//  Top level: config decode, range check and clamp, error pulse, cfg_ready, toggle generator.
// TESTING
//  1 Reset: RST pulse mid-run -> dout=0, busy=0, cfg_ready=1, all channel latencies = DEFAULT_DLY+2.
//  2 Latency sweep: each dly 0..15 on ch0, single-cycle din[0] pulse at cycle t -> dout[0] high at exactly t+dly+2.
//  3 Reconfig: ch1 streaming 1010...; write dly 3->9 -> dout[1] frozen for 2 cycles, busy[1]=1,
//    cfg_ready=0 for 2 cycles, then correct 9-cycle-aligned data.
//  4 Errors: cfg_ch=5 (NCH=4) -> cfg_err pulse, no state change;
//    cfg_dly=20 with a 5-bit port -> dly=15, cfg_err pulse.
//  5 Back-pressure: two back-to-back transfers to ch0 then ch2 -> second accepted only after busy clears,
//    inputs held stable in between.
//  6 Source select: cfg_src=1 on ch3 -> after freeze, dout[3] toggles every cycle, independent of din[3].
//    Then RST during FREEZE -> immediate reset values.

Source files
------------

// File: rtl/rd53_delay_pkg.sv
// Shared widths, state encoding and width helper for the programmable delay line.
`timescale 1ns/1ps
package rd53_delay_pkg;

  // Bits needed to hold the value itself (not value-1), minimum 1.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if ((value >> i) != 0) width = i + 1;
    end
    return width;
  endfunction

  localparam int NCH_DEFAULT     = 4;
  localparam int MAX_DLY_DEFAULT = 15;
  localparam int CH_W            = clog2(NCH_DEFAULT);
  localparam int DLY_W           = clog2(MAX_DLY_DEFAULT + 1);
  localparam int CNT_W           = 4;

  typedef enum logic {
    IDLE,
    FREEZE
  } freeze_state_t;

endpackage

// File: rtl/rd53_delay_chan.sv
// One delay channel: shift register, tap and source muxes, freeze FSM and output register.
`timescale 1ns/1ps
module rd53_delay_chan
  import rd53_delay_pkg::*;
#(
  parameter int MAX_DLY     = 15,
  parameter int DEFAULT_DLY = 0,
  parameter int FREEZE_CYC  = 2,
  parameter int DLY_WIDTH   = clog2(MAX_DLY + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 din_i,
  input  logic                 toggle_i,
  input  logic                 cfg_we_i,
  input  logic [DLY_WIDTH-1:0] cfg_dly_i,
  input  logic                 cfg_src_i,
  output logic                 dout_o,
  output logic                 busy_o
);

  logic [MAX_DLY:0]   sr_q, sr_d;
  logic [DLY_WIDTH-1:0] dly_q, dly_d;
  logic               src_q, src_d;
  logic               dout_q, dout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  freeze_state_t      state_q, state_d;
  logic               src_bit;
  logic               tap;

  always_comb begin
    src_bit = src_q ? toggle_i : din_i;
    sr_d    = {sr_q[MAX_DLY-1:0], src_bit};
    tap     = 1'b0;
    for (int i = 0; i <= MAX_DLY; i++) begin
      if (dly_q == DLY_WIDTH'(i)) tap = sr_q[i];
    end
  end

  // The shift register keeps running while frozen; only the output register is held.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    dly_d   = dly_q;
    src_d   = src_q;
    if (cfg_we_i) begin
      dly_d = cfg_dly_i;
      src_d = cfg_src_i;
    end
    case (state_q)
      IDLE: begin
        dout_d = tap;
        if (cfg_we_i) begin
          state_d = FREEZE;
          cnt_d   = CNT_W'(FREEZE_CYC - 1);
        end
      end
      FREEZE: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q    <= '0;
      dly_q   <= DLY_WIDTH'(DEFAULT_DLY);
      src_q   <= 1'b0;
      dout_q  <= 1'b0;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      sr_q    <= sr_d;
      dly_q   <= dly_d;
      src_q   <= src_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign dout_o = dout_q;
  assign busy_o = (state_q == FREEZE);

endmodule

// File: rtl/rd53_prog_delay_line.sv
// Multi-channel programmable delay line: config decode, range check/clamp, error pulse, toggle source.
`timescale 1ns/1ps
module rd53_prog_delay_line
  import rd53_delay_pkg::*;
#(
  parameter  int NCH         = 4,
  parameter  int MAX_DLY     = 15,
  parameter  int DEFAULT_DLY = 0,
  parameter  int FREEZE_CYC  = 2,
  localparam int CH_WIDTH    = clog2(NCH),
  localparam int DLY_WIDTH   = clog2(MAX_DLY + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NCH-1:0]       din_i,
  output logic [NCH-1:0]       dout_o,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [CH_WIDTH-1:0]  cfg_ch_i,
  input  logic [DLY_WIDTH-1:0] cfg_dly_i,
  input  logic                 cfg_src_i,
  output logic                 cfg_err_o,
  output logic [NCH-1:0]       busy_o
);

  logic                 accept;
  logic                 ch_bad;
  logic                 dly_over;
  logic [DLY_WIDTH-1:0] dly_eff;
  logic [NCH-1:0]       cfg_we;
  logic                 toggle_q, toggle_d;
  logic                 cfg_err_q, cfg_err_d;

  // Range checks use the full port value, so out-of-range high bits are caught.
  always_comb begin
    accept    = cfg_valid_i & cfg_ready_o;
    ch_bad    = (32'(cfg_ch_i) >= NCH);
    dly_over  = (32'(cfg_dly_i) > MAX_DLY);
    dly_eff   = dly_over ? DLY_WIDTH'(MAX_DLY) : cfg_dly_i;
    cfg_err_d = accept & (ch_bad | dly_over);
    toggle_d  = ~toggle_q;
    cfg_we    = '0;
    for (int c = 0; c < NCH; c++) begin
      if (accept && !ch_bad && (cfg_ch_i == CH_WIDTH'(c))) cfg_we[c] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      toggle_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      toggle_q  <= toggle_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    rd53_delay_chan #(
      .MAX_DLY     (MAX_DLY),
      .DEFAULT_DLY (DEFAULT_DLY),
      .FREEZE_CYC  (FREEZE_CYC),
      .DLY_WIDTH   (DLY_WIDTH)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .din_i     (din_i[g]),
      .toggle_i  (toggle_q),
      .cfg_we_i  (cfg_we[g]),
      .cfg_dly_i (dly_eff),
      .cfg_src_i (cfg_src_i),
      .dout_o    (dout_o[g]),
      .busy_o    (busy_o[g])
    );
  end

  // Only one channel may be mid-freeze, so a busy channel blocks all config.
  assign cfg_ready_o = ~|busy_o;
  assign cfg_err_o   = cfg_err_q;

endmodule
